// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and coordinate width for the
// raster generator and its per-axis counters.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;

  localparam int H_TOTAL     = H_SYNC_DEF + H_BACK_DEF + H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int V_TOTAL     = V_SYNC_DEF + V_BACK_DEF + V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int H_ACT_START = H_SYNC_DEF + H_BACK_DEF;
  localparam int V_ACT_START = V_SYNC_DEF + V_BACK_DEF;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter whose sync and active flags are registered
// from the next-state count, so they line up with the count itself.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF,
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  output coord_t count_o,
  output logic   wrap_o,
  output logic   sync_n_o,
  output logic   active_o
);

  localparam int TOTAL     = SYNC + BACK + VISIBLE + FRONT;
  localparam int ACT_START = SYNC + BACK;
  localparam int ACT_END   = SYNC + BACK + VISIBLE;

  if (TOTAL > (1 << COORD_W)) begin : g_total_too_large
    $error("vga_axis_counter: axis total exceeds coordinate range");
  end

  coord_t count_q, count_d;
  logic   sync_n_q, active_q;
  int     count_next;

  assign wrap_o = en_i && (int'(count_q) == TOTAL - 1);

  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch.
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + coord_t'(1);
    end
    count_next = int'(count_d);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      sync_n_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_n_q <= count_next >= SYNC;
      active_q <= (count_next >= ACT_START) && (count_next < ACT_END);
    end
  end

  assign count_o  = count_q;
  assign sync_n_o = sync_n_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Define VGA_TIMING_SYNC_DELAY_EN to delay
// HS/VS/BLANK_N by one pixel relative to VGA_X/VGA_Y.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF
) (
  input  logic         VGA_CLK,
  input  logic         reset,
  input  logic         pixel_en,
  output logic [9:0]   VGA_X,
  output logic [9:0]   VGA_Y,
  output logic         VGA_HS,
  output logic         VGA_VS,
  output logic         VGA_BLANK_N,
  output logic         VGA_SYNC_N,
  output logic         line_start,
  output logic         frame_start
);

  logic h_wrap, h_sync_n, h_active;
  logic v_wrap, v_sync_n, v_active;
  logic line_start_q, frame_start_q;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT)
  ) u_h_axis (
    .clk(VGA_CLK), .rst(reset), .en_i(pixel_en),
    .count_o(VGA_X), .wrap_o(h_wrap), .sync_n_o(h_sync_n), .active_o(h_active)
  );

  // The vertical axis steps only on the pixel where the line wraps.
  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT)
  ) u_v_axis (
    .clk(VGA_CLK), .rst(reset), .en_i(h_wrap),
    .count_o(VGA_Y), .wrap_o(v_wrap), .sync_n_o(v_sync_n), .active_o(v_active)
  );

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

`ifdef VGA_TIMING_SYNC_DELAY_EN
  logic hs_q, vs_q, blank_n_q;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      blank_n_q <= 1'b0;
    end else if (pixel_en) begin
      hs_q      <= h_sync_n;
      vs_q      <= v_sync_n;
      blank_n_q <= h_active && v_active;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
`else
  assign VGA_HS      = h_sync_n;
  assign VGA_VS      = v_sync_n;
  assign VGA_BLANK_N = h_active && v_active;
`endif

  assign VGA_SYNC_N  = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: directed vectors on the 640x480 instance, plus a
// reduced-geometry instance for full-frame and pixel_en-toggling sequences.
module tb_vga_timing;

  logic       clk = 1'b0;
  logic       rst_b, pen_b, rst_s, pen_s;
  logic [9:0] x_b, y_b, x_s, y_s;
  logic       hs_b, vs_b, bl_b, sy_b, ls_b, fs_b;
  logic       hs_s, vs_s, bl_s, sy_s, ls_s, fs_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing dut (
    .VGA_CLK(clk), .reset(rst_b), .pixel_en(pen_b),
    .VGA_X(x_b), .VGA_Y(y_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sy_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // Small geometry: H = 2/3/4/1 (total 10), V = 2/2/3/1 (total 8).
  vga_timing #(
    .H_SYNC(2), .H_BACK(3), .H_VISIBLE(4), .H_FRONT(1),
    .V_SYNC(2), .V_BACK(2), .V_VISIBLE(3), .V_FRONT(1)
  ) dut_s (
    .VGA_CLK(clk), .reset(rst_s), .pixel_en(pen_s),
    .VGA_X(x_s), .VGA_Y(y_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
    .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sy_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic blank_n;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[16];
  int   cnt;

  task automatic step_b();
    @(posedge clk);
    cnt++;
    @(negedge clk);
  endtask

  initial begin
    int target, px, py;
    logic e_hs, e_vs, e_bl;
    int x_m, y_m, en_cnt, clk_cnt, last_clk, last_en, last_phase;
    int ls_run, fs_run, max_ls, max_fs;
    bit have_last;
    logic ls_m, fs_m, hs_l, vs_l, bl_l;

    vecs[0]  = '{1,   0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{95,  0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{96,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{144, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{799, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{0,   1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1,   1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{0,   2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{144, 34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{143, 35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{144, 35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{783, 35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{784, 35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{799, 35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{0,   36, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{400, 36, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_b = 1'b1; pen_b = 1'b1; rst_s = 1'b1; pen_s = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_x", 32'(x_b), 0);
    check("rst_y", 32'(y_b), 0);
    check("rst_hs", 32'(hs_b), 0);
    check("rst_vs", 32'(vs_b), 0);
    check("rst_blank_n", 32'(bl_b), 0);
    check("rst_line_start", 32'(ls_b), 0);
    check("rst_frame_start", 32'(fs_b), 0);
    check("sync_n_const", 32'(sy_b), 0);

    // Full-size instance: walk the directed vectors in ascending raster order.
    rst_b = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      target = vecs[i].y * 800 + vecs[i].x;
      while (cnt < target) step_b();
`ifdef VGA_TIMING_SYNC_DELAY_EN
      px = (cnt - 1) % 800;
      py = (cnt - 1) / 800;
      e_hs = (px >= 96);
      e_vs = (py >= 2);
      e_bl = (px >= 144) && (px < 784) && (py >= 35) && (py < 515);
`else
      px = 0; py = 0;
      e_hs = vecs[i].hs;
      e_vs = vecs[i].vs;
      e_bl = vecs[i].blank_n;
`endif
      check($sformatf("vec%0d_x", i), 32'(x_b), 32'(vecs[i].x));
      check($sformatf("vec%0d_y", i), 32'(y_b), 32'(vecs[i].y));
      check($sformatf("vec%0d_hs", i), 32'(hs_b), 32'(e_hs));
      check($sformatf("vec%0d_vs", i), 32'(vs_b), 32'(e_vs));
      check($sformatf("vec%0d_blank_n", i), 32'(bl_b), 32'(e_bl));
      check($sformatf("vec%0d_line_start", i), 32'(ls_b), 32'(vecs[i].ls));
      check($sformatf("vec%0d_frame_start", i), 32'(fs_b), 32'(vecs[i].fs));
    end

    // Mid-frame reset must clear outputs before the next clock edge.
    rst_b = 1'b1;
    #1;
    check("async_rst_x", 32'(x_b), 0);
    check("async_rst_y", 32'(y_b), 0);
    check("async_rst_hs", 32'(hs_b), 0);
    check("async_rst_vs", 32'(vs_b), 0);
    check("async_rst_blank_n", 32'(bl_b), 0);
    check("async_rst_line_start", 32'(ls_b), 0);
    check("async_rst_frame_start", 32'(fs_b), 0);
    @(negedge clk);
    rst_b = 1'b0;
    cnt = 0;
    step_b();
    check("post_rst_x", 32'(x_b), 1);
    check("post_rst_y", 32'(y_b), 0);

    // Small instance: model-checked every cycle, continuous then toggled pixel_en.
    rst_s = 1'b0;
    x_m = 0; y_m = 0; ls_m = 1'b0; fs_m = 1'b0;
    hs_l = 1'b0; vs_l = 1'b0; bl_l = 1'b0;
    en_cnt = 0; clk_cnt = 0; have_last = 1'b0;
    last_clk = 0; last_en = 0; last_phase = 0;
    ls_run = 0; fs_run = 0; max_ls = 0; max_fs = 0;
    for (int i = 0; i < 600; i++) begin
      pen_s = (i < 200) ? 1'b1 : ((i % 2) == 0);
      @(posedge clk);
      clk_cnt++;
      if (pen_s) begin
        en_cnt++;
        hs_l = (x_m >= 2);
        vs_l = (y_m >= 2);
        bl_l = (x_m >= 5) && (x_m < 9) && (y_m >= 4) && (y_m < 7);
        if (x_m == 9) begin
          x_m = 0;
          y_m = (y_m == 7) ? 0 : y_m + 1;
        end else begin
          x_m = x_m + 1;
        end
        ls_m = (x_m == 0);
        fs_m = (x_m == 0) && (y_m == 0);
      end else begin
        ls_m = 1'b0;
        fs_m = 1'b0;
      end
      @(negedge clk);
`ifdef VGA_TIMING_SYNC_DELAY_EN
      e_hs = hs_l; e_vs = vs_l; e_bl = bl_l;
`else
      e_hs = (x_m >= 2);
      e_vs = (y_m >= 2);
      e_bl = (x_m >= 5) && (x_m < 9) && (y_m >= 4) && (y_m < 7);
`endif
      check("s_x", 32'(x_s), 32'(x_m));
      check("s_y", 32'(y_s), 32'(y_m));
      check("s_hs", 32'(hs_s), 32'(e_hs));
      check("s_vs", 32'(vs_s), 32'(e_vs));
      check("s_blank_n", 32'(bl_s), 32'(e_bl));
      check("s_line_start", 32'(ls_s), 32'(ls_m));
      check("s_frame_start", 32'(fs_s), 32'(fs_m));

      ls_run = (ls_s === 1'b1) ? ls_run + 1 : 0;
      fs_run = (fs_s === 1'b1) ? fs_run + 1 : 0;
      if (ls_run > max_ls) max_ls = ls_run;
      if (fs_run > max_fs) max_fs = fs_run;

      if (fs_s === 1'b1) begin
        if (have_last && last_phase == ((i < 200) ? 0 : 1)) begin
          if (i < 200) begin
            check("s_frame_clocks", 32'(clk_cnt - last_clk), 80);
          end else begin
            check("s_frame_clocks_toggled", 32'(clk_cnt - last_clk), 160);
            check("s_frame_pixels_toggled", 32'(en_cnt - last_en), 80);
          end
        end
        have_last = 1'b1;
        last_clk = clk_cnt;
        last_en = en_cnt;
        last_phase = (i < 200) ? 0 : 1;
      end
    end
    check("s_line_start_max_width", 32'(max_ls), 1);
    check("s_frame_start_max_width", 32'(max_fs), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Generates 640x480@60 Hz VGA raster timing: free-running horizontal/vertical counters, active-low sync pulses, blanking, and frame/line strobes. It is the producer end of the VGA_X/VGA_Y interface consumed by the screen renderer (tela) and drives the DAC control pins directly. Counter origin is the start of the sync pulse, so the visible area begins at X = H_SYNC+H_BACK (144) and Y = V_SYNC+V_BACK (35).

Parameters:
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch

Ports:
VGA_CLK  in  1  pixel clock domain; all state on rising edge
reset  in  1  asynchronous, active-high reset
pixel_en  in  1  counters advance only on cycles where high; tie 1 for 25 MHz VGA_CLK
VGA_X  out  10  horizontal counter, 0..H_TOTAL-1
VGA_Y  out  10  vertical counter, 0..V_TOTAL-1
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  high only inside the visible window
VGA_SYNC_N  out  1  constant 0 (no sync-on-green)
line_start  out  1  one-cycle pulse when VGA_X wraps to 0
frame_start  out  1  one-cycle pulse when VGA_X and VGA_Y both wrap to 0

Behaviour:
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be at most 1024; otherwise elaboration fails.
- Reset, asynchronous: VGA_X = 0, VGA_Y = 0, VGA_HS = 0, VGA_VS = 0, VGA_BLANK_N = 0, line_start = 0, frame_start = 0.
- Reset mid-frame takes effect immediately. The first count after reset release is 0 -> 1, so the first frame after reset is full length.
- Counting, on a rising edge with pixel_en = 1:
  - If VGA_X = H_TOTAL-1: VGA_X <= 0 and the vertical counter steps. If VGA_Y = V_TOTAL-1, VGA_Y <= 0; otherwise VGA_Y <= VGA_Y+1.
  - Otherwise VGA_X <= VGA_X+1.
- pixel_en = 0: every register holds its value, and the strobes go to 0 that cycle.
- Outputs are registered and decoded from the next-state counter values, so sync, blank and strobes are cycle-aligned with VGA_X/VGA_Y (zero relative latency).
  - VGA_HS = 0 iff X < H_SYNC.
  - VGA_VS = 0 iff Y < V_SYNC.
  - VGA_BLANK_N = 1 iff H_SYNC+H_BACK <= X < H_SYNC+H_BACK+H_VISIBLE and V_SYNC+V_BACK <= Y < V_SYNC+V_BACK+V_VISIBLE.
  - line_start = 1 for the single enabled cycle in which X = 0.
  - frame_start = 1 for the single enabled cycle in which X = 0 and Y = 0.
- Sequencing is implicit in the counters; there is no separate FSM. Phase boundaries are the parameter sums.

Optional Feature:
Macro: VGA_TIMING_SYNC_DELAY_EN.
- Defined: VGA_HS, VGA_VS and VGA_BLANK_N pass through one extra pixel_en-qualified register stage, so they lag VGA_X/VGA_Y by exactly one pixel. This aligns them with a renderer that registers RGB one cycle after sampling the coordinates. Reset values of the delay stage: HS = 0, VS = 0, BLANK_N = 0.
- Not defined: zero-lag alignment as specified in Behaviour.
- VGA_X, VGA_Y, line_start and frame_start are unaffected either way.

Decomposition:
- Shared package vga_pkg:
  - the eight timing defaults;
  - derived constants H_TOTAL, V_TOTAL, H_ACT_START (144), V_ACT_START (35);
  - coordinate width 10.
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - inputs: enable, parameters SYNC/BACK/VISIBLE/FRONT;
  - outputs: count, wrap, sync_n, active.
  - The horizontal wrap drives the vertical enable.

Test Plan:
- Hold reset, release, pixel_en = 1: at the first edge X = 1, Y = 0, HS = 0, BLANK_N = 0. At X = 96, HS rises to 1. At X = 144 with Y = 35, BLANK_N = 1. At X = 784, BLANK_N = 0.
- Run a full line: X = 799 -> 0, Y increments by 1, line_start pulses for exactly 1 cycle.
- Run a full frame: VS = 0 only for Y in {0,1}. X = 799, Y = 524 -> X = 0, Y = 0 with frame_start = 1. Exactly 420000 enabled cycles between frame_start pulses.
- Toggle pixel_en 1,0,1,0: counters advance every other cycle, strobes never last longer than one cycle, and a frame spans 840000 clocks.
- Assert reset at X = 400, Y = 200: all outputs return to reset values asynchronously, before the next edge.
- With VGA_TIMING_SYNC_DELAY_EN defined: BLANK_N rises at the edge after X becomes 144 (Y = 35), and HS rises when X = 97.
